ex_stage: RTL and testbench

//   Execute stage of the 5-stage MIPS pipeline, directly downstream of ID.
//   - Registers id_to_ex_bus and runs the one-hot ALU.
//   - Drives the data SRAM request and builds ex_to_mem_bus for MEM.
//   - Returns the forwarding and load-in-EX signals to ID.
//   - Optionally runs an iterative 32-cycle divider for div/divu, stalling the pipe while it works.

---
 rtl/ex_stage.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage: execute stage of the 5-stage MIPS pipeline (downstream of ID).
//
// Holds the ID/EX pipeline register, evaluates the one-hot ALU, drives the
// data SRAM request and builds the bus handed to MEM. Forwarding data and a
// "load in EX" flag go back to ID.
//
// Optional feature macro: EX_DIV_EN
//   defined   -> iterative 32-step restoring divider for div/divu, which holds
//                the pipe through stallreq_for_ex and writes HI/LO once.
//   undefined -> div/divu behave as NOPs; stallreq_for_ex, hilo_we and
//                hilo_wdata are tied to 0.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   stall[5:0]             per-stage stall, bit 2 = EX, 1 = stop
//   id_to_ex_bus[158:0]    {pc,inst,alu_op,src1,src2,ram_en,ram_wen,rf_we,
//                           rf_waddr,sel_rf_res,rs_val,rt_val}
//   ex_to_mem_bus[75:0]    {pc,ram_en,ram_wen,sel_rf_res,rf_we,rf_waddr,result}
//   ex_to_id_forwarding    {rf_we,rf_waddr,result}
//   ex_aluop               load currently in EX
//   stallreq_for_ex        divider busy, EX must hold
//   data_sram_*            data SRAM request
//   hilo_we, hilo_wdata    one-cycle HI/LO write, {HI=remainder, LO=quotient}
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [37:0]             ex_to_id_forwarding,
    output logic                    ex_aluop,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    hilo_we,
    output logic [63:0]             hilo_wdata
);

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    logic [ID_TO_EX_WD-1:0] pipe_q;
    logic [ID_TO_EX_WD-1:0] pipe_d;

    // Next pipeline value: bubble when EX stops but MEM runs, capture when EX runs
    always_comb begin
        pipe_d = pipe_q;
        if (stall[2] && !stall[3]) begin
            pipe_d = {ID_TO_EX_WD{1'b0}};
        end else if (!stall[2]) begin
            pipe_d = id_to_ex_bus;
        end else begin
            pipe_d = pipe_q;
        end
    end

    // Pipeline register state
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= {ID_TO_EX_WD{1'b0}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Field decode of the registered bus
    logic [31:0] pc_s;
    logic [31:0] inst_s;
    logic [11:0] alu_op_s;
    logic [2:0]  src1_sel_s;
    logic [3:0]  src2_sel_s;
    logic        ram_en_s;
    logic [3:0]  ram_wen_s;
    logic        rf_we_s;
    logic [4:0]  rf_waddr_s;
    logic        sel_rf_res_s;
    logic [31:0] rs_val_s;
    logic [31:0] rt_val_s;

    assign {pc_s, inst_s, alu_op_s, src1_sel_s, src2_sel_s, ram_en_s, ram_wen_s,
            rf_we_s, rf_waddr_s, sel_rf_res_s, rs_val_s, rt_val_s} = pipe_q;

    logic is_div_s;
    assign is_div_s = (inst_s[31:26] == 6'h00) &&
                      ((inst_s[5:0] == 6'h1A) || (inst_s[5:0] == 6'h1B));

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] src1_s;
    logic [31:0] src2_s;
    logic [4:0]  sa_s;
    logic [31:0] sra_s;
    logic [31:0] ex_result_s;

    // Operand muxes and one-hot result merge; unselected terms contribute 0
    always_comb begin
        src1_s = ({32{src1_sel_s[0]}} & rs_val_s)
               | ({32{src1_sel_s[1]}} & pc_s)
               | ({32{src1_sel_s[2]}} & {27'd0, inst_s[10:6]});
        src2_s = ({32{src2_sel_s[0]}} & rt_val_s)
               | ({32{src2_sel_s[1]}} & {{16{inst_s[15]}}, inst_s[15:0]})
               | ({32{src2_sel_s[2]}} & 32'd8)
               | ({32{src2_sel_s[3]}} & {16'd0, inst_s[15:0]});
        sa_s   = src1_s[4:0];
        sra_s  = $unsigned($signed(src2_s) >>> sa_s);
        ex_result_s = ({32{alu_op_s[11]}} & (src1_s + src2_s))
                    | ({32{alu_op_s[10]}} & (src1_s - src2_s))
                    | ({32{alu_op_s[9]}}  & {31'd0, ($signed(src1_s) < $signed(src2_s))})
                    | ({32{alu_op_s[8]}}  & {31'd0, (src1_s < src2_s)})
                    | ({32{alu_op_s[7]}}  & (src1_s & src2_s))
                    | ({32{alu_op_s[6]}}  & ~(src1_s | src2_s))
                    | ({32{alu_op_s[5]}}  & (src1_s | src2_s))
                    | ({32{alu_op_s[4]}}  & (src1_s ^ src2_s))
                    | ({32{alu_op_s[3]}}  & (src2_s << sa_s))
                    | ({32{alu_op_s[2]}}  & (src2_s >> sa_s))
                    | ({32{alu_op_s[1]}}  & sra_s)
                    | ({32{alu_op_s[0]}}  & {src2_s[15:0], 16'd0});
    end

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic div_nop_s;

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    div_state_e  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] quo_q, quo_d;      // dividend shifts out MSB-first, quotient shifts in
    logic [32:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dvz_q, dvz_d;      // divisor was zero
    logic        hilo_we_q, hilo_we_d;
    logic [63:0] hilo_wdata_q, hilo_wdata_d;

    logic [32:0] rem_sh_s;
    logic        ge_s;
    logic [32:0] rem_step_s;
    logic [31:0] quo_step_s;
    logic [31:0] hi_s;
    logic [31:0] lo_s;
    logic        div_signed_s;

    // Divider next state: one restoring step per RUN cycle, result latched on the last step
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        dvs_d        = dvs_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        dvz_d        = dvz_q;
        hilo_we_d    = 1'b0;
        hilo_wdata_d = hilo_wdata_q;

        div_signed_s = (inst_s[5:0] == 6'h1A);
        rem_sh_s     = {rem_q[31:0], quo_q[31]};
        ge_s         = (rem_sh_s >= {1'b0, dvs_q});
        rem_step_s   = ge_s ? (rem_sh_s - {1'b0, dvs_q}) : rem_sh_s;
        quo_step_s   = {quo_q[30:0], ge_s};
        // Sign fix-up; a zero divisor leaves |rs| in the remainder, so HI = rs_val
        hi_s = r_neg_q ? (~rem_step_s[31:0] + 32'd1) : rem_step_s[31:0];
        if (dvz_q) begin
            lo_s = 32'hFFFF_FFFF;
        end else if (q_neg_q) begin
            lo_s = ~quo_step_s + 32'd1;
        end else begin
            lo_s = quo_step_s;
        end

        case (state_q)
            DIV_IDLE: begin
                if (is_div_s) begin
                    state_d = DIV_RUN;
                    count_d = 5'd0;
                    rem_d   = 33'd0;
                    if (div_signed_s) begin
                        quo_d   = rs_val_s[31] ? (~rs_val_s + 32'd1) : rs_val_s;
                        dvs_d   = rt_val_s[31] ? (~rt_val_s + 32'd1) : rt_val_s;
                        q_neg_d = rs_val_s[31] ^ rt_val_s[31];
                        r_neg_d = rs_val_s[31];
                    end else begin
                        quo_d   = rs_val_s;
                        dvs_d   = rt_val_s;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                    end
                    dvz_d = (rt_val_s == 32'd0);
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                rem_d   = rem_step_s;
                quo_d   = quo_step_s;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d      = DIV_DONE;
                    hilo_we_d    = 1'b1;
                    hilo_wdata_d = {hi_s, lo_s};
                end else begin
                    state_d = DIV_RUN;
                end
            end
            DIV_DONE: begin
                // Leave only when EX advances, so a held div is not started again
                if (!stall[2]) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d = DIV_DONE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DIV_IDLE;
            count_q      <= 5'd0;
            quo_q        <= 32'd0;
            rem_q        <= 33'd0;
            dvs_q        <= 32'd0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            dvz_q        <= 1'b0;
            hilo_we_q    <= 1'b0;
            hilo_wdata_q <= 64'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            dvs_q        <= dvs_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            dvz_q        <= dvz_d;
            hilo_we_q    <= hilo_we_d;
            hilo_wdata_q <= hilo_wdata_d;
        end
    end

    assign stallreq_for_ex = is_div_s && (state_q != DIV_DONE);
    assign hilo_we         = hilo_we_q;
    assign hilo_wdata      = hilo_wdata_q;
    assign div_nop_s       = 1'b0;
`else
    assign stallreq_for_ex = 1'b0;
    assign hilo_we         = 1'b0;
    assign hilo_wdata      = 64'd0;
    assign div_nop_s       = is_div_s;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic       ram_en_eff_s;
    logic [3:0] ram_wen_eff_s;
    logic       rf_we_eff_s;

    assign ram_en_eff_s  = ram_en_s & ~div_nop_s;
    assign ram_wen_eff_s = ram_wen_s & {4{~div_nop_s}};
    assign rf_we_eff_s   = rf_we_s & ~div_nop_s;

    assign ex_to_mem_bus = {pc_s, ram_en_eff_s, ram_wen_eff_s, sel_rf_res_s,
                            rf_we_eff_s, rf_waddr_s, ex_result_s};
    assign ex_to_id_forwarding = {rf_we_eff_s, rf_waddr_s, ex_result_s};
    assign ex_aluop        = ram_en_eff_s && (ram_wen_eff_s == 4'd0);
    assign data_sram_en    = ram_en_eff_s;
    assign data_sram_wen   = ram_wen_eff_s;
    assign data_sram_addr  = ex_result_s;
    assign data_sram_wdata = rt_val_s;

    // Fields this stage does not consume
    logic unused_s;
    assign unused_s = ^{inst_s[25:16], stall[STALL_WD-1:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: reset, ALU, store/load, stall/bubble and,
// when EX_DIV_EN is defined, the iterative divider.
module tb_ex_stage;
    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id_forwarding;
    logic         ex_aluop;
    logic         stallreq_for_ex;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         hilo_we;
    logic [63:0]  hilo_wdata;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [11:0] OP_ADD  = 12'h800;
    localparam logic [11:0] OP_SUB  = 12'h400;
    localparam logic [11:0] OP_SLT  = 12'h200;
    localparam logic [11:0] OP_SLTU = 12'h100;
    localparam logic [11:0] OP_AND  = 12'h080;
    localparam logic [11:0] OP_NOR  = 12'h040;
    localparam logic [11:0] OP_OR   = 12'h020;
    localparam logic [11:0] OP_XOR  = 12'h010;
    localparam logic [11:0] OP_SLL  = 12'h008;
    localparam logic [11:0] OP_SRL  = 12'h004;
    localparam logic [11:0] OP_SRA  = 12'h002;
    localparam logic [11:0] OP_LUI  = 12'h001;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .id_to_ex_bus        (id_to_ex_bus),
        .ex_to_mem_bus       (ex_to_mem_bus),
        .ex_to_id_forwarding (ex_to_id_forwarding),
        .ex_aluop            (ex_aluop),
        .stallreq_for_ex     (stallreq_for_ex),
        .data_sram_en        (data_sram_en),
        .data_sram_wen       (data_sram_wen),
        .data_sram_addr      (data_sram_addr),
        .data_sram_wdata     (data_sram_wdata),
        .hilo_we             (hilo_we),
        .hilo_wdata          (hilo_wdata)
    );

    logic [249:0] all_out;
    assign all_out = {ex_to_mem_bus, ex_to_id_forwarding, ex_aluop, stallreq_for_ex,
                      data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                      hilo_we, hilo_wdata};

    function automatic logic [158:0] mk_bus(input logic [31:0] pc, input logic [31:0] inst,
                                            input logic [11:0] op, input logic [2:0] s1,
                                            input logic [3:0] s2, input logic ren,
                                            input logic [3:0] wen, input logic we,
                                            input logic [4:0] wa, input logic sel,
                                            input logic [31:0] rs, input logic [31:0] rt);
        return {pc, inst, op, s1, s2, ren, wen, we, wa, sel, rs, rt};
    endfunction

    function automatic logic [75:0] mk_mem(input logic [31:0] pc, input logic en,
                                           input logic [3:0] wen, input logic sel,
                                           input logic we, input logic [4:0] wa,
                                           input logic [31:0] res);
        return {pc, en, wen, sel, we, wa, res};
    endfunction

    function automatic logic [158:0] mk_div(input logic [31:0] rs, input logic [31:0] rt,
                                            input logic is_signed);
        logic [31:0] inst;
        inst = {6'h00, 5'd1, 5'd2, 10'd0, (is_signed ? 6'h1A : 6'h1B)};
        return mk_bus(32'h0040_0100, inst, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                      1'b0, 5'd0, 1'b0, rs, rt);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        rst = 1'b1;
        stall = 6'b000000;
        id_to_ex_bus = r[158:0];
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (all_out !== 250'd0) begin
                n_err++;
                $display("FAIL reset_outputs cycle %0d: got %h want 0", i, all_out);
            end
        end
        rst = 1'b0;
        id_to_ex_bus = 159'd0;
    endtask

    typedef struct {
        string       name;
        logic [11:0] op;
        logic [2:0]  s1;
        logic [3:0]  s2;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp;
    } alu_vec_t;

    task automatic test_alu();
        alu_vec_t v[$];
        logic [75:0] exp_mem;
        v.push_back('{"ori",    OP_OR,   3'b001, 4'b1000, 32'h0, 32'h3422_000F, 32'h0000_00F0, 32'h0, 32'h0000_00FF});
        v.push_back('{"slt",    OP_SLT,  3'b001, 4'b0001, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h1});
        v.push_back('{"sltu",   OP_SLTU, 3'b001, 4'b0001, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0});
        v.push_back('{"slt_r",  OP_SLT,  3'b001, 4'b0001, 32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0});
        v.push_back('{"sltu_r", OP_SLTU, 3'b001, 4'b0001, 32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'h1});
        v.push_back('{"add_wrap", OP_ADD, 3'b001, 4'b0001, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0});
        v.push_back('{"sub",    OP_SUB,  3'b001, 4'b0001, 32'h0, 32'h0, 32'h5, 32'h7, 32'hFFFF_FFFE});
        v.push_back('{"addi_sx", OP_ADD, 3'b001, 4'b0010, 32'h0, 32'h2022_FFFC, 32'h10, 32'h0, 32'hC});
        v.push_back('{"sll_sa", OP_SLL,  3'b100, 4'b0001, 32'h0, 32'h0000_0100, 32'h0, 32'h1, 32'h10});
        v.push_back('{"sra_sa", OP_SRA,  3'b100, 4'b0001, 32'h0, 32'h0000_0100, 32'h0, 32'h8000_0000, 32'hF800_0000});
        v.push_back('{"srl_sa", OP_SRL,  3'b100, 4'b0001, 32'h0, 32'h0000_0100, 32'h0, 32'h8000_0000, 32'h0800_0000});
        v.push_back('{"sllv",   OP_SLL,  3'b001, 4'b0001, 32'h0, 32'h0, 32'h24, 32'h1, 32'h10});
        v.push_back('{"lui",    OP_LUI,  3'b000, 4'b1000, 32'h0, 32'h3C01_1234, 32'h0, 32'h0, 32'h1234_0000});
        v.push_back('{"nor",    OP_NOR,  3'b001, 4'b0001, 32'h0, 32'h0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F});
        v.push_back('{"xor",    OP_XOR,  3'b001, 4'b0001, 32'h0, 32'h0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0});
        v.push_back('{"and",    OP_AND,  3'b001, 4'b0001, 32'h0, 32'h0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00});
        v.push_back('{"pc_8",   OP_ADD,  3'b010, 4'b0100, 32'h0040_0000, 32'h0, 32'h0, 32'h0, 32'h0040_0008});
        v.push_back('{"no_op",  12'h000, 3'b001, 4'b0001, 32'h0, 32'h0, 32'h5, 32'h7, 32'h0});
        v.push_back('{"no_src", OP_ADD,  3'b000, 4'b0000, 32'h0, 32'h0, 32'h5, 32'h7, 32'h0});
        stall = 6'b000000;
        foreach (v[i]) begin
            id_to_ex_bus = mk_bus(v[i].pc, v[i].inst, v[i].op, v[i].s1, v[i].s2, 1'b0, 4'h0,
                                  1'b1, 5'd2, 1'b0, v[i].rs, v[i].rt);
            tick();
            exp_mem = mk_mem(v[i].pc, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, v[i].exp);
            n_cmp++;
            if (ex_to_mem_bus !== exp_mem) begin
                n_err++;
                $display("FAIL alu_%s mem_bus: got %h want %h", v[i].name, ex_to_mem_bus, exp_mem);
            end
            n_cmp++;
            if (ex_to_id_forwarding !== {1'b1, 5'd2, v[i].exp}) begin
                n_err++;
                $display("FAIL alu_%s fwd: got %h want %h", v[i].name, ex_to_id_forwarding,
                         {1'b1, 5'd2, v[i].exp});
            end
        end
    endtask

    task automatic test_store_load();
        stall = 6'b000000;
        id_to_ex_bus = mk_bus(32'h0040_0010, 32'hAC22_0008, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF,
                              1'b0, 5'd0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        tick();
        n_cmp++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_aluop} !==
            {1'b1, 4'hF, 32'h0000_0108, 32'hDEAD_BEEF, 1'b0}) begin
            n_err++;
            $display("FAIL sw_sram: got en=%b wen=%h addr=%h wdata=%h ld=%b want 1 f 00000108 deadbeef 0",
                     data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_aluop);
        end
        id_to_ex_bus = mk_bus(32'h0040_0014, 32'h8C22_0008, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0,
                              1'b1, 5'd2, 1'b1, 32'h0000_0100, 32'h0);
        tick();
        n_cmp++;
        if ({ex_aluop, data_sram_en, data_sram_wen, data_sram_addr} !== {1'b1, 1'b1, 4'h0, 32'h0000_0108}) begin
            n_err++;
            $display("FAIL lw_sram: got ld=%b en=%b wen=%h addr=%h want 1 1 0 00000108",
                     ex_aluop, data_sram_en, data_sram_wen, data_sram_addr);
        end
        n_cmp++;
        if (ex_to_mem_bus !== mk_mem(32'h0040_0014, 1'b1, 4'h0, 1'b1, 1'b1, 5'd2, 32'h0000_0108)) begin
            n_err++;
            $display("FAIL lw_mem_bus: got %h want %h", ex_to_mem_bus,
                     mk_mem(32'h0040_0014, 1'b1, 4'h0, 1'b1, 1'b1, 5'd2, 32'h0000_0108));
        end
    endtask

    task automatic test_bubble();
        logic [75:0] exp_a;
        logic [158:0] bus_b;
        exp_a = mk_mem(32'hBFC0_0010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h0000_00FF);
        bus_b = mk_bus(32'h0040_0020, 32'hAC22_0008, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF,
                       1'b0, 5'd0, 1'b0, 32'h0000_0100, 32'h1234_5678);
        stall = 6'b000000;
        id_to_ex_bus = mk_bus(32'hBFC0_0010, 32'h3422_000F, OP_OR, 3'b001, 4'b1000, 1'b0, 4'h0,
                              1'b1, 5'd2, 1'b0, 32'h0000_00F0, 32'h0);
        tick();
        id_to_ex_bus = bus_b;
        stall = 6'b001111;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (ex_to_mem_bus !== exp_a) begin
                n_err++;
                $display("FAIL hold_%0d: got %h want %h", i, ex_to_mem_bus, exp_a);
            end
        end
        stall = 6'b000111;
        tick();
        n_cmp++;
        if ({ex_to_mem_bus, ex_to_id_forwarding, data_sram_en} !== 115'd0) begin
            n_err++;
            $display("FAIL bubble: got mem=%h fwd=%h en=%b want 0", ex_to_mem_bus,
                     ex_to_id_forwarding, data_sram_en);
        end
        stall = 6'b000011;
        tick();
        n_cmp++;
        if ({data_sram_en, data_sram_addr, data_sram_wdata} !== {1'b1, 32'h0000_0108, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL capture_ex_run: got en=%b addr=%h wdata=%h want 1 00000108 12345678",
                     data_sram_en, data_sram_addr, data_sram_wdata);
        end
        stall = 6'b000000;
        id_to_ex_bus = 159'd0;
        tick();
    endtask

`ifdef EX_DIV_EN
    // Steps while the divider requests a stall, with a bounded cycle budget
    task automatic run_to_done(output int cycles, output int early_we);
        cycles = 0;
        early_we = 0;
        while (stallreq_for_ex === 1'b1 && cycles < 100) begin
            stall = 6'b001111;
            cycles++;
            if (hilo_we !== 1'b0) early_we++;
            tick();
        end
    endtask

    task automatic test_signed_div();
        int cyc;
        int ew;
        stall = 6'b000000;
        id_to_ex_bus = mk_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        tick();
        run_to_done(cyc, ew);
        n_cmp++;
        if (cyc !== 33 || ew !== 0) begin
            n_err++;
            $display("FAIL div_stall_len: got %0d cycles (%0d early we) want 33 (0)", cyc, ew);
        end
        n_cmp++;
        if ({hilo_we, hilo_wdata} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            n_err++;
            $display("FAIL div_m7_2: got we=%b hilo=%h want 1 fffffffffffffffd", hilo_we, hilo_wdata);
        end
        // back-to-back: divu 7/0 enters as the first div leaves
        stall = 6'b000000;
        id_to_ex_bus = mk_div(32'd7, 32'd0, 1'b0);
        tick();
        n_cmp++;
        if ({hilo_we, stallreq_for_ex} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_start: got we=%b stallreq=%b want 0 1", hilo_we, stallreq_for_ex);
        end
        run_to_done(cyc, ew);
        n_cmp++;
        if (cyc !== 33 || ew !== 0 || {hilo_we, hilo_wdata} !== {1'b1, 32'd7, 32'hFFFF_FFFF}) begin
            n_err++;
            $display("FAIL divu_7_0: got %0d cycles we=%b hilo=%h want 33 1 00000007ffffffff",
                     cyc, hilo_we, hilo_wdata);
        end
        stall = 6'b000000;
        id_to_ex_bus = 159'd0;
        tick();
    endtask

    task automatic test_div_results();
        logic [31:0] rs_t[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'd100};
        logic [31:0] rt_t[4] = '{32'd2, 32'd2, 32'd0, 32'd7};
        logic        sg_t[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [63:0] ex_t[4] = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0001_7FFF_FFFF,
                                 64'hFFFF_FFF8_FFFF_FFFF, 64'h0000_0002_0000_000E};
        int cyc;
        int ew;
        for (int i = 0; i < 4; i++) begin
            stall = 6'b000000;
            id_to_ex_bus = mk_div(rs_t[i], rt_t[i], sg_t[i]);
            tick();
            run_to_done(cyc, ew);
            n_cmp++;
            if (cyc !== 33 || ew !== 0 || {hilo_we, hilo_wdata} !== {1'b1, ex_t[i]}) begin
                n_err++;
                $display("FAIL div_vec%0d: got %0d cycles we=%b hilo=%h want 33 1 %h",
                         i, cyc, hilo_we, hilo_wdata, ex_t[i]);
            end
            stall = 6'b000000;
            id_to_ex_bus = 159'd0;
            tick();
            n_cmp++;
            if (hilo_we !== 1'b0) begin
                n_err++;
                $display("FAIL div_vec%0d_pulse: got we=%b want 0", i, hilo_we);
            end
        end
    endtask

    task automatic test_div_reset();
        int cyc;
        int ew;
        stall = 6'b000000;
        id_to_ex_bus = mk_div(32'd100, 32'd3, 1'b0);
        tick();
        stall = 6'b001111;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({stallreq_for_ex, hilo_we, hilo_wdata} !== 66'd0) begin
            n_err++;
            $display("FAIL div_rst: got stallreq=%b we=%b hilo=%h want 0", stallreq_for_ex,
                     hilo_we, hilo_wdata);
        end
        rst = 1'b0;
        stall = 6'b000000;
        id_to_ex_bus = mk_div(32'd100, 32'd7, 1'b0);
        tick();
        run_to_done(cyc, ew);
        n_cmp++;
        if (cyc !== 33 || ew !== 0 || {hilo_we, hilo_wdata} !== {1'b1, 64'h0000_0002_0000_000E}) begin
            n_err++;
            $display("FAIL div_after_rst: got %0d cycles we=%b hilo=%h want 33 1 000000020000000e",
                     cyc, hilo_we, hilo_wdata);
        end
        stall = 6'b000000;
        id_to_ex_bus = 159'd0;
        tick();
    endtask

    task automatic test_div_hold();
        int cyc;
        int ew;
        stall = 6'b000000;
        id_to_ex_bus = mk_div(32'd20, 32'd3, 1'b0);
        tick();
        run_to_done(cyc, ew);
        n_cmp++;
        if (cyc !== 33 || {hilo_we, hilo_wdata} !== {1'b1, 64'h0000_0002_0000_0006}) begin
            n_err++;
            $display("FAIL hold_first: got %0d cycles we=%b hilo=%h want 33 1 0000000200000006",
                     cyc, hilo_we, hilo_wdata);
        end
        stall = 6'b001111;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({hilo_we, stallreq_for_ex, hilo_wdata} !== {2'b00, 64'h0000_0002_0000_0006}) begin
                n_err++;
                $display("FAIL hold_done_%0d: got we=%b stallreq=%b hilo=%h want 0 0 0000000200000006",
                         i, hilo_we, stallreq_for_ex, hilo_wdata);
            end
        end
        stall = 6'b000000;
        id_to_ex_bus = 159'd0;
        tick();
        n_cmp++;
        if ({hilo_we, stallreq_for_ex} !== 2'b00) begin
            n_err++;
            $display("FAIL hold_release: got we=%b stallreq=%b want 0 0", hilo_we, stallreq_for_ex);
        end
    endtask
`else
    task automatic test_div_disabled();
        logic [158:0] b;
        b = mk_div(32'd7, 32'd2, 1'b1);
        b[70] = 1'b1;
        stall = 6'b000000;
        id_to_ex_bus = b;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({stallreq_for_ex, hilo_we, hilo_wdata, ex_to_id_forwarding[37]} !== 67'd0) begin
                n_err++;
                $display("FAIL div_nop_%0d: got stallreq=%b we=%b hilo=%h rf_we=%b want 0",
                         i, stallreq_for_ex, hilo_we, hilo_wdata, ex_to_id_forwarding[37]);
            end
        end
        id_to_ex_bus = 159'd0;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        stall = 6'b000000;
        id_to_ex_bus = 159'd0;
        test_reset();
        test_alu();
        test_store_load();
        test_bubble();
`ifdef EX_DIV_EN
        test_signed_div();
        test_div_results();
        test_div_reset();
        test_div_hold();
`else
        test_div_disabled();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
